driver_paso_eje: RTL and testbench

Single-axis stepper-motor driver on the receiving end of the tracker's direction-command interface. It consumes the 2-bit command produced by the photoresistor tracking controller (00 stop, 01 clockwise, 11 counter-clockwise) and generates a timed full-step 4-coil phase sequence. It also keeps the 16-bit step-count position that is fed back to the controller as `teta_actual` / `fi_actual`. One instance is used per axis (teta, fi).

---
 rtl/driver_paso_eje_if.sv | 21 ++
 rtl/driver_paso_eje.sv | 129 ++++++++++++
 tb/tb_driver_paso_eje.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/driver_paso_eje_if.sv
// Direction-command in, coil drive and position feedback out, for one stepper axis.
// master = tracker side (drives enable/cmd), slave = driver side.
interface driver_paso_eje_if;
   logic        enable;
   logic [1:0]  cmd;
   logic [3:0]  coil;
   logic [15:0] position;
   logic        moving;
   logic        step_pulse;
   logic        at_limit;

   modport master (
      output enable, cmd,
      input  coil, position, moving, step_pulse, at_limit
   );

   modport slave (
      input  enable, cmd,
      output coil, position, moving, step_pulse, at_limit
   );
endinterface

// File: rtl/driver_paso_eje.sv
// Full-step stepper driver: cmd registered, RUN one edge later, a step every DIV cycles.
// No backpressure; reversals pass through a DIV-cycle dwell, limits stop motion without stepping.
module driver_paso_eje #(
   parameter int          DIV     = 50000,
   parameter logic [15:0] POS_MIN = 16'd0,
   parameter logic [15:0] POS_MAX = 16'd3600,
   parameter bit          HOLD    = 1'b1
) (
   input logic              clk,
   input logic              rst_n,
   driver_paso_eje_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DWELL} state_t;

   localparam logic [15:0] RELOAD = 16'(DIV - 1);

   state_t      state;
   logic [1:0]  cmd_q;
   logic [15:0] cnt;
   logic [15:0] position;
   logic [1:0]  idx;
   logic        dir_ccw;
   logic [3:0]  coil;
   logic        moving;
   logic        step_pulse;

   logic        active;
   logic        cmd_ccw;
   logic        blocked;
   logic [1:0]  idx_step;
   logic [3:0]  hold_coil;

   function automatic logic [3:0] phase(input logic [1:0] i);
      case (i)
         2'd0: return 4'b0011;
         2'd1: return 4'b0110;
         2'd2: return 4'b1100;
         2'd3: return 4'b1001;
      endcase
   endfunction

   // 01 = CW, 11 = CCW; bit 0 clear means stop (00) or reserved (10)
   assign active    = cmd_q[0];
   assign cmd_ccw   = cmd_q[1];
   assign blocked   = active && (cmd_ccw ? (position == POS_MIN) : (position == POS_MAX));
   assign idx_step  = dir_ccw ? (idx - 2'd1) : (idx + 2'd1);
   assign hold_coil = HOLD ? phase(idx) : 4'b0000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q <= 2'b00;
      end else begin
         cmd_q <= bus.cmd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 16'd0;
         position   <= POS_MIN;
         idx        <= 2'd0;
         dir_ccw    <= 1'b0;
         coil       <= 4'b0000;
         moving     <= 1'b0;
         step_pulse <= 1'b0;
      end else begin
         step_pulse <= 1'b0;
         if (!bus.enable) begin
            state  <= IDLE;
            moving <= 1'b0;
            coil   <= 4'b0000;
            cnt    <= 16'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (active && !blocked) begin
                     state   <= RUN;
                     moving  <= 1'b1;
                     dir_ccw <= cmd_ccw;
                     cnt     <= RELOAD;
                     coil    <= phase(idx);
                  end else begin
                     coil <= hold_coil;
                  end
               end
               RUN, DWELL: begin
                  if (!active) begin
                     state  <= IDLE;
                     moving <= 1'b0;
                     coil   <= hold_coil;
                  end else if (cmd_ccw != dir_ccw) begin
                     // reversal (or re-reversal during dead time) restarts the dwell
                     state   <= DWELL;
                     dir_ccw <= cmd_ccw;
                     cnt     <= RELOAD;
                     coil    <= phase(idx);
                  end else if (cnt != 16'd0) begin
                     cnt <= cnt - 16'd1;
                  end else if (state == DWELL) begin
                     state <= RUN;
                     cnt   <= RELOAD;
                  end else if (blocked) begin
                     state  <= IDLE;
                     moving <= 1'b0;
                     coil   <= hold_coil;
                  end else begin
                     idx        <= idx_step;
                     coil       <= phase(idx_step);
                     position   <= dir_ccw ? (position - 16'd1) : (position + 16'd1);
                     step_pulse <= 1'b1;
                     cnt        <= RELOAD;
                  end
               end
               default: begin
                  state  <= IDLE;
                  moving <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.coil       = coil;
   assign bus.position   = position;
   assign bus.moving     = moving;
   assign bus.step_pulse = step_pulse;
   assign bus.at_limit   = blocked;
endmodule

// File: tb/tb_driver_paso_eje.sv
// Bench for driver_paso_eje: directed scenarios plus random cmd/enable traffic against a step-timing model.
module tb_driver_paso_eje;
   localparam int DIV  = 4;
   localparam int PMIN = 0;
   localparam int PMAX = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [1:0] cmd = 2'b00;

   driver_paso_eje_if b1();
   driver_paso_eje_if b2();

   assign b1.enable = en;
   assign b1.cmd    = cmd;
   assign b2.enable = en;
   assign b2.cmd    = cmd;

   driver_paso_eje #(.DIV(DIV), .POS_MIN(16'(PMIN)), .POS_MAX(16'(PMAX)), .HOLD(1'b1))
      dut (.clk(clk), .rst_n(rst_n), .bus(b1));
   driver_paso_eje #(.DIV(DIV), .POS_MIN(16'(PMIN)), .POS_MAX(16'(PMAX)), .HOLD(1'b0))
      dut_nohold (.clk(clk), .rst_n(rst_n), .bus(b2));

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: mode 0 stopped, 1 running, 2 reversal dead time; elapsed counts cycles in the interval
   logic [3:0] tbl [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
   logic [1:0] m_q;
   int         m_mode, m_el, m_dir, m_pos, m_ph;
   logic [3:0] m_coil, m_coil2;
   logic       m_pulse;

   localparam logic [26:0] RESET_VEC = 27'd0;

   task automatic model_reset();
      m_q = 2'b00; m_mode = 0; m_el = 0; m_dir = 1; m_pos = PMIN; m_ph = 0;
      m_coil = 4'b0000; m_coil2 = 4'b0000; m_pulse = 1'b0;
   endtask

   function automatic logic m_lim();
      return m_q[0] && (m_q[1] ? (m_pos == PMIN) : (m_pos == PMAX));
   endfunction

   task automatic model_edge();
      bit act, blk;
      int qdir;
      act  = m_q[0];
      qdir = m_q[1] ? -1 : 1;
      blk  = m_lim();
      m_pulse = 1'b0;
      if (!en) m_mode = 0;
      else if (m_mode == 0) begin
         if (act && !blk) begin m_mode = 1; m_dir = qdir; m_el = 0; end
      end else if (!act) m_mode = 0;
      else if (qdir != m_dir) begin m_mode = 2; m_dir = qdir; m_el = 0; end
      else begin
         m_el++;
         if (m_el == DIV) begin
            m_el = 0;
            if (m_mode == 2) m_mode = 1;
            else if (blk) m_mode = 0;
            else begin
               m_pos  += m_dir;
               m_ph    = (m_ph + m_dir + 4) % 4;
               m_pulse = 1'b1;
            end
         end
      end
      m_coil  = en ? tbl[m_ph] : 4'b0000;
      m_coil2 = (en && m_mode != 0) ? tbl[m_ph] : 4'b0000;
      m_q = cmd;
   endtask

   function automatic logic [26:0] observed();
      return {b1.coil, b1.position, b1.moving, b1.step_pulse, b1.at_limit, b2.coil};
   endfunction

   function automatic logic [26:0] expected();
      return {m_coil, 16'(m_pos), (m_mode != 0), m_pulse, m_lim(), m_coil2};
   endfunction

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic reinit();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1; en = 1'b1; cmd = 2'b00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; cmd = 2'b00;
      model_reset();
      repeat (2) @(negedge clk);
      n_chk++;
      if (observed() !== RESET_VEC) $display("FAIL reset_state: got %h want %h", observed(), RESET_VEC);
      else n_pass++;
      rst_n = 1'b1; en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         n_chk++;
         if (observed() !== expected()) $display("FAIL reset_hold cyc %0d: got %h want %h", i, observed(), expected());
         else n_pass++;
         if (i == 0) begin
            n_chk++;
            if (b1.coil !== 4'b0011) $display("FAIL first_hold_coil: got %b want 0011", b1.coil);
            else n_pass++;
         end
      end
   endtask

   task automatic test_cw_run();
      logic [3:0] seq [4] = '{4'b0110, 4'b1100, 4'b1001, 4'b0011};
      int first = -1, k = 0;
      reinit();
      cmd = 2'b01;
      for (int i = 0; i < 20; i++) begin
         cyc();
         n_chk++;
         if (observed() !== expected()) $display("FAIL cw_run cyc %0d: got %h want %h", i, observed(), expected());
         else n_pass++;
         if (b1.step_pulse === 1'b1) begin
            if (first < 0) first = i;
            if (k < 4) begin
               n_chk++;
               if (b1.coil !== seq[k] || b1.position !== 16'(k + 1))
                  $display("FAIL cw_seq step %0d: got coil %b pos %0d want coil %b pos %0d", k, b1.coil, b1.position, seq[k], k + 1);
               else n_pass++;
            end
            k++;
         end
      end
      n_chk++;
      if (first != 5) $display("FAIL cw_first_pulse: got cycle %0d want 5", first);
      else n_pass++;
   endtask

   task automatic test_reversal();
      int first = -1;
      reinit();
      cmd = 2'b01;
      for (int i = 0; i < 100 && m_pos != 3; i++) begin
         cyc();
         n_chk++;
         if (observed() !== expected()) $display("FAIL rev_fwd cyc %0d: got %h want %h", i, observed(), expected());
         else n_pass++;
      end
      n_chk++;
      if (m_pos != 3 || b1.position !== 16'd3) $display("FAIL rev_reach3: got %0d want 3", b1.position);
      else n_pass++;
      cmd = 2'b11;
      for (int i = 0; i < 12; i++) begin
         cyc();
         n_chk++;
         if (observed() !== expected()) $display("FAIL rev_back cyc %0d: got %h want %h", i, observed(), expected());
         else n_pass++;
         if (b1.step_pulse === 1'b1 && first < 0) begin
            first = i;
            n_chk++;
            if (b1.position !== 16'd2 || b1.coil !== 4'b1100)
               $display("FAIL rev_step: got pos %0d coil %b want pos 2 coil 1100", b1.position, b1.coil);
            else n_pass++;
         end
      end
      n_chk++;
      if (first != 9) $display("FAIL rev_timing: got cycle %0d want 9", first);
      else n_pass++;
   endtask

   task automatic test_upper_limit();
      int pulses = 0;
      reinit();
      cmd = 2'b01;
      for (int i = 0; i < 40; i++) begin
         cyc();
         n_chk++;
         if (observed() !== expected()) $display("FAIL upper cyc %0d: got %h want %h", i, observed(), expected());
         else n_pass++;
         if (b1.step_pulse === 1'b1) pulses++;
      end
      n_chk++;
      if (pulses != 5 || b1.position !== 16'd5 || b1.at_limit !== 1'b1 || b1.moving !== 1'b0)
         $display("FAIL upper_stop: got pulses %0d pos %0d lim %b mov %b want 5 5 1 0", pulses, b1.position, b1.at_limit, b1.moving);
      else n_pass++;
      cmd = 2'b11;
      for (int i = 0; i < 10; i++) begin
         cyc();
         n_chk++;
         if (observed() !== expected()) $display("FAIL upper_back cyc %0d: got %h want %h", i, observed(), expected());
         else n_pass++;
      end
      n_chk++;
      if (b1.position !== 16'd3 || b1.at_limit !== 1'b0)
         $display("FAIL upper_release: got pos %0d lim %b want pos 3 lim 0", b1.position, b1.at_limit);
      else n_pass++;
   endtask

   task automatic test_lower_limit();
      int pulses = 0;
      reinit();
      cmd = 2'b11;
      for (int i = 0; i < 10; i++) begin
         cyc();
         n_chk++;
         if (observed() !== expected()) $display("FAIL lower cyc %0d: got %h want %h", i, observed(), expected());
         else n_pass++;
         if (b1.step_pulse === 1'b1) pulses++;
      end
      n_chk++;
      if (pulses != 0 || b1.at_limit !== 1'b1 || b1.position !== 16'd0)
         $display("FAIL lower_block: got pulses %0d lim %b pos %0d want 0 1 0", pulses, b1.at_limit, b1.position);
      else n_pass++;
      cmd = 2'b01;
      for (int i = 0; i < 60 && m_pos != 4; i++) begin
         cyc();
         n_chk++;
         if (observed() !== expected()) $display("FAIL lower_fwd cyc %0d: got %h want %h", i, observed(), expected());
         else n_pass++;
      end
      cmd = 2'b11;
      for (int i = 0; i < 20; i++) begin
         cyc();
         n_chk++;
         if (observed() !== expected()) $display("FAIL lower_wrap cyc %0d: got %h want %h", i, observed(), expected());
         else n_pass++;
         if (b1.step_pulse === 1'b1) break;
      end
      n_chk++;
      if (b1.step_pulse !== 1'b1 || b1.coil !== 4'b1001 || b1.position !== 16'd3)
         $display("FAIL lower_wrap_step: got pulse %b coil %b pos %0d want 1 1001 3", b1.step_pulse, b1.coil, b1.position);
      else n_pass++;
   endtask

   task automatic test_enable_drop();
      reinit();
      cmd = 2'b01;
      for (int i = 0; i < 7; i++) begin
         cyc();
         n_chk++;
         if (observed() !== expected()) $display("FAIL en_run cyc %0d: got %h want %h", i, observed(), expected());
         else n_pass++;
      end
      en = 1'b0;
      cyc();
      n_chk++;
      if (b1.coil !== 4'b0000 || b1.position !== 16'd1 || b1.moving !== 1'b0)
         $display("FAIL en_drop: got coil %b pos %0d mov %b want 0000 1 0", b1.coil, b1.position, b1.moving);
      else n_pass++;
      for (int i = 0; i < 16; i++) begin
         if (i == 6) en = 1'b1;
         cyc();
         n_chk++;
         if (observed() !== expected()) $display("FAIL en_resume cyc %0d: got %h want %h", i, observed(), expected());
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      reinit();
      cmd = 2'b01;
      for (int i = 0; i < 11; i++) begin
         cyc();
         n_chk++;
         if (observed() !== expected()) $display("FAIL rstmid_run cyc %0d: got %h want %h", i, observed(), expected());
         else n_pass++;
      end
      @(posedge clk);
      model_edge();
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (observed() !== RESET_VEC) $display("FAIL reset_async: got %h want %h", observed(), RESET_VEC);
      else n_pass++;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         n_chk++;
         if (observed() !== expected()) $display("FAIL rstmid_after cyc %0d: got %h want %h", i, observed(), expected());
         else n_pass++;
      end
   endtask

   task automatic test_random();
      reinit();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) cmd = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 30) == 0) en = ($urandom_range(0, 5) != 0);
         cyc();
         n_chk++;
         if (observed() !== expected()) $display("FAIL random cyc %0d: got %h want %h", i, observed(), expected());
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_cw_run();
      test_reversal();
      test_upper_limit();
      test_lower_limit();
      test_enable_drop();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
